// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with registered one-hot grant and bounded hold time.
// Latency: req to gnt is 1 cycle; one grant-free gap cycle between grants. No backpressure; the grantee holds req.
module rr_arb4_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       valid,
  output logic       timeout,
  output logic       any
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       pri;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic             pick_vld;
  logic [1:0]       idx;

  assign any = |req;

  // Scan from the highest offset down so the lowest offset from pri wins.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    idx      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = pri + 2'(i);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pri     <= 2'd0;
      cnt     <= '0;
      gnt     <= 4'b0000;
      gnt_id  <= 2'd0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        BUSY: begin
          if (!req[gnt_id]) begin
            // A release wins over a simultaneous timeout.
            gnt    <= 4'b0000;
            gnt_id <= 2'd0;
            valid  <= 1'b0;
            pri    <= gnt_id + 2'd1;
            state  <= GAP;
          end else if (MAX_HOLD != 0 && cnt == HOLD_LAST) begin
            gnt     <= 4'b0000;
            gnt_id  <= 2'd0;
            valid   <= 1'b0;
            timeout <= 1'b1;
            pri     <= gnt_id + 2'd1;
            state   <= GAP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (pick_vld) begin
            gnt    <= 4'b0001 << pick;
            gnt_id <= pick;
            valid  <= 1'b1;
            cnt    <= '0;
            state  <= BUSY;
          end else begin
            gnt    <= 4'b0000;
            gnt_id <= 2'd0;
            valid  <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Bench for rr_arb4_ctrl: table vectors plus hand sequences, checked through an expectation queue.
module tb_rr_arb4_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       valid;
  logic       timeout;
  logic       any;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       to;
  } vec_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  rr_arb4_ctrl #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
    .valid(valid), .timeout(timeout), .any(any)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    oh2id = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) oh2id = 2'(i);
  endfunction

  function automatic logic [3:0] onehot(input int i);
    onehot = 4'b0001 << i;
  endfunction

  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input logic eto);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r;
    req = rq;
    e.gnt = eg;
    e.id  = oh2id(eg);
    e.vld = |eg;
    e.to  = eto;
    sb.push_back(e);
    #1;
    n_vec++;
    if (any !== |rq) begin
      n_bad++;
      $display("FAIL %s any: got %b want %b (req=%b)", name, any, |rq, rq);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = '{gnt, gnt_id, valid, timeout};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b id=%0d vld=%b to=%b want gnt=%b id=%0d vld=%b to=%b",
               name, gnt, gnt_id, valid, timeout, e.gnt, e.id, e.vld, e.to);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // Reset, first grant, then skip-over rotation with REQ=1011.
    tbl[0] = '{1'b1, 4'b1111, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 4'b1111, 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 4'b0001, 4'b0001, 1'b0};
    tbl[3] = '{1'b0, 4'b1011, 4'b0001, 1'b0};
    tbl[4] = '{1'b0, 4'b1010, 4'b0000, 1'b0};
    tbl[5] = '{1'b0, 4'b1010, 4'b0010, 1'b0};
    tbl[6] = '{1'b0, 4'b1000, 4'b0000, 1'b0};
    tbl[7] = '{1'b0, 4'b1000, 4'b1000, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[9] = '{1'b0, 4'b0000, 4'b0000, 1'b0};
    for (int i = 0; i < 10; i++)
      step("table", tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].to);

    // Full contention, each grantee holds 3 cycles: order 0,1,2,3,0 with PRI wrap.
    for (int i = 0; i < 5; i++) begin
      step("rr_grant", 1'b0, 4'b1111, onehot(i % 4), 1'b0);
      step("rr_hold", 1'b0, 4'b1111, onehot(i % 4), 1'b0);
      step("rr_hold", 1'b0, 4'b1111, onehot(i % 4), 1'b0);
      step("rr_release", 1'b0, 4'b1111 & ~onehot(i % 4), 4'b0000, 1'b0);
    end
    step("idle", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Held request times out after exactly 16 grant cycles, then regrants.
    step("to_grant", 1'b0, 4'b0100, 4'b0100, 1'b0);
    for (int i = 0; i < 15; i++) step("to_hold", 1'b0, 4'b0100, 4'b0100, 1'b0);
    step("to_pulse", 1'b0, 4'b0100, 4'b0000, 1'b1);
    step("to_regrant", 1'b0, 4'b0100, 4'b0100, 1'b0);

    // Reset in the middle of a grant to requester 2.
    for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 4'b0100, 4'b0100, 1'b0);
    step("rst_mid", 1'b1, 4'b0100, 4'b0000, 1'b0);
    step("rst_pri0", 1'b0, 4'b1111, 4'b0001, 1'b0);
    step("rst_rel", 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("idle", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Release on the would-be timeout cycle counts as release, no pulse.
    step("rt_grant", 1'b0, 4'b0001, 4'b0001, 1'b0);
    for (int i = 0; i < 15; i++) step("rt_hold", 1'b0, 4'b0001, 4'b0001, 1'b0);
    step("rt_release", 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("rt_after", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // ANY follows REQ combinationally mid-cycle.
    @(negedge clk);
    #2 req = 4'b1000;
    #1;
    n_vec++;
    if (any !== 1'b1) begin
      n_bad++;
      $display("FAIL any_mid_set: got %b want 1", any);
    end
    req = 4'b0000;
    #1;
    n_vec++;
    if (any !== 1'b0) begin
      n_bad++;
      $display("FAIL any_mid_clr: got %b want 0", any);
    end

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_empty: got %0d entries want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
